row_reduction_sequencer: RTL and testbench
==========================================

# row_reduction_sequencer

Controller that sequences the eight-lane row adder/organizer through a configured matrix-vector job. It accepts a job (row count, chunks per row) and streams 8-element chunks into the organizer. It also clears the organizer's accumulator between rows, counts chunk completions, and returns one 32-bit row sum per row through a ready/valid result port. It sits between the operand fetch stream and the organizer in the row-reduction path.

## Interface
- ELEMENT_WIDTH, 32, width of one float element and of the result
- NO_OF_UNITS, 8, elements per chunk
- ROW_W, 10, width of row count/index
- CHUNK_W, 5, width of chunks-per-row count
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid / cfg_ready  in / out  1  job handshake
- cfg_num_rows  in  ROW_W  rows in job
- cfg_chunks_per_row  in  CHUNK_W  chunks per row
- chunk_valid / chunk_ready  in / out  1  operand chunk handshake
- chunk_data  in  NO_OF_UNITS*ELEMENT_WIDTH  8 packed elements
- org_start  out  1  organizer start; low clears accumulator
- org_chunk_strobe  out  1  one-cycle chunk-present pulse to organizer
- org_row_input  out  NO_OF_UNITS*ELEMENT_WIDTH  registered chunk to organizer
- org_final_finish  in  1  organizer final-adder completion pulse, one per chunk
- org_adder_output  in  ELEMENT_WIDTH  organizer running sum
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  ELEMENT_WIDTH  row sum
- res_row_idx  out  ROW_W  row index of res_data
- res_last  out  1  result is last row of job
- busy  out  1  not IDLE
- err_spurious  out  1  sticky: completion outside FEED/DRAIN
- err_cfg  out  1  sticky: zero rows or zero chunks requested

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, OUTPUT.
- IDLE:
  - cfg_ready=1.
  - On a cfg handshake with both counts nonzero, latch the counts, set row_idx=0, go to CLEAR.
  - On a handshake with either count zero, set err_cfg and stay in IDLE.
- CLEAR:
  - org_start=0 for exactly 2 cycles.
  - Clear issue_cnt and done_cnt, then go to FEED.
- FEED:
  - org_start=1; chunk_ready=1 while issue_cnt<chunks_per_row.
  - Each accepted chunk is registered into org_row_input, pulses org_chunk_strobe, and increments issue_cnt.
  - After the last chunk is accepted, go to DRAIN.
- FEED and DRAIN: each org_final_finish increments done_cnt.
- When done_cnt reaches chunks_per_row, capture org_adder_output into res_data in that same cycle and go to OUTPUT.
- OUTPUT:
  - res_valid=1; res_data, res_row_idx and res_last are held stable until res_ready.
  - On the handshake: if this was the last row, go to IDLE; otherwise row_idx+1 and go to CLEAR.
- org_final_finish in IDLE, CLEAR or OUTPUT sets err_spurious and is otherwise ignored. Completions beyond chunks_per_row are also ignored.
- Error flags clear only on reset or on the next accepted valid cfg.

## Timing
- Reset values:
  - 0: cfg_ready, chunk_ready, org_start, org_chunk_strobe, org_row_input, res_valid, res_data, res_row_idx, res_last, busy, err_spurious, err_cfg.
  - State is IDLE; cfg_ready goes to 1 on the first clock after reset release.
- cfg handshake at cycle T: org_start is low at T+1 and T+2; chunk_ready=1 from T+3.
- Chunk accepted at cycle C: org_row_input is valid and org_chunk_strobe=1 at C+1. Back-to-back chunks are allowed, at one per cycle.
- chunk_ready drops in the cycle after the last chunk is accepted. No chunk beyond chunks_per_row is ever accepted.
- Final completion in cycle F: res_valid=1 from F+1.
- Result handshake in cycle R: the next row's CLEAR begins at R+1.
- A completion that coincides with the last chunk acceptance counts normally.
- Asserting rst_n mid-job aborts immediately: all outputs return to reset values, and the partial row is discarded.

## Structure
- A shared package holds:
  - state encoding enum;
  - CLEAR_CYCLES=2;
  - default widths ELEMENT_WIDTH, NO_OF_UNITS, ROW_W, CHUNK_W.
- One sub-module, `chunk_completion_counter`: issue/done counters, the chunks_per_row comparison, and spurious detection.
- FSM and result register live in the top module, which instantiates the organizer externally; it does not contain it.

## Test plan
The bench uses a behavioural organizer model with 5-cycle chunk-to-finish latency and float sums.
- Job rows=1, chunks=2, all elements 0x3F800000 (1.0) → one result 0x41800000 (16.0), res_row_idx=0, res_last=1, then IDLE.
- Job rows=3, chunks=1, row k elements = k+1.0 → results 8.0, 16.0, 24.0, in order. org_start is low for exactly 2 cycles before each row.
- res_ready held low 10 cycles in OUTPUT → res_data stable, chunk_ready=0, no org_start toggle. Progress resumes the cycle after the handshake.
- chunk_valid stalls (1 of every 3 cycles) with chunks=4 → exactly 4 strobes, sum correct, chunk_ready low after the 4th acceptance.
- cfg_chunks_per_row=0 → err_cfg=1, busy stays 0. An org_final_finish pulse in IDLE → err_spurious=1.
- rst_n asserted in DRAIN of row 1 of 2 → all outputs at reset values. A new job then completes normally with correct sums.

Source files
------------

// File: rtl/row_reduction_sequencer_pkg.sv
// Shared definitions for the row reduction sequencer slice.
// Holds the FSM state encoding, the length of the accumulator clear window
// and the default datapath widths used by the top and its sub-module.
package row_reduction_sequencer_pkg;

    // Default widths (overridable through the top-level parameters)
    localparam int DEF_ELEMENT_WIDTH = 32;
    localparam int DEF_NO_OF_UNITS   = 8;
    localparam int DEF_ROW_W         = 10;
    localparam int DEF_CHUNK_W       = 5;

    // Number of cycles org_start is held low between rows
    localparam int CLEAR_CYCLES = 2;

    // FSM state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CLEAR  = 3'd1;
    localparam state_t ST_FEED   = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_OUTPUT = 3'd4;

endpackage

// File: rtl/row_reduction_sequencer_chunk_counter.sv
// chunk_completion_counter
// Tracks how many chunks of the current row have been issued to the organizer
// and how many final-adder completions have come back.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           zero both counters (held during the clear window)
//   chunks_per_row  configured chunks per row
//   count_window    high while completions are expected (FEED or DRAIN)
//   chunk_accept    a chunk is being accepted this cycle
//   final_finish    organizer completion pulse
//   issue_room      more chunks may still be issued for this row
//   last_issue      the chunk accepted this cycle is the row's last one
//   last_done       the completion this cycle finishes the row
//   spurious        completion arrived outside the counting window
module chunk_completion_counter
    import row_reduction_sequencer_pkg::*;
#(
    parameter int CHUNK_W = DEF_CHUNK_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [CHUNK_W-1:0] chunks_per_row,
    input  logic               count_window,
    input  logic               chunk_accept,
    input  logic               final_finish,
    output logic               issue_room,
    output logic               last_issue,
    output logic               last_done,
    output logic               spurious
);

    logic [CHUNK_W-1:0] issue_cnt;
    logic [CHUNK_W-1:0] done_cnt;
    logic               counted_finish;

    assign issue_room     = (issue_cnt < chunks_per_row);
    assign last_issue     = chunk_accept && (issue_cnt == chunks_per_row - 1'b1);
    // Completions beyond the configured count are dropped silently
    assign counted_finish = final_finish && count_window && (done_cnt < chunks_per_row);
    assign last_done      = counted_finish && (done_cnt == chunks_per_row - 1'b1);
    assign spurious       = final_finish && !count_window;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            done_cnt  <= '0;
        end else if (clear) begin
            issue_cnt <= '0;
            done_cnt  <= '0;
        end else begin
            if (chunk_accept && issue_room) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (counted_finish) begin
                done_cnt <= done_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/row_reduction_sequencer.sv
// row_reduction_sequencer
// Sequences the external eight-lane row adder/organizer through a job of
// cfg_num_rows rows, each made of cfg_chunks_per_row 8-element chunks.
// Between rows the organizer accumulator is cleared by holding org_start low.
// Handshakes: a transfer happens on any rising clk edge where valid and ready
// are both high; valid never waits on ready, and a producer holds its payload
// stable while valid is high and ready is low.
// Ports:
//   cfg_*        job request (row count, chunks per row)
//   chunk_*      operand chunk stream in
//   org_*        organizer control/data out, completion and running sum in
//   res_*        one row sum per row, with row index and last-row flag
//   busy         controller not idle
//   err_*        sticky error flags, cleared by the next accepted valid job
module row_reduction_sequencer
    import row_reduction_sequencer_pkg::*;
#(
    parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS,
    parameter int ROW_W         = DEF_ROW_W,
    parameter int CHUNK_W       = DEF_CHUNK_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [ROW_W-1:0]                     cfg_num_rows,
    input  logic [CHUNK_W-1:0]                   cfg_chunks_per_row,
    input  logic                                 chunk_valid,
    output logic                                 chunk_ready,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] chunk_data,
    output logic                                 org_start,
    output logic                                 org_chunk_strobe,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] org_row_input,
    input  logic                                 org_final_finish,
    input  logic [ELEMENT_WIDTH-1:0]             org_adder_output,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [ELEMENT_WIDTH-1:0]             res_data,
    output logic [ROW_W-1:0]                     res_row_idx,
    output logic                                 res_last,
    output logic                                 busy,
    output logic                                 err_spurious,
    output logic                                 err_cfg
);

    localparam logic [1:0] CLEAR_LAST = 2'(CLEAR_CYCLES - 1);

    state_t             state;
    logic               out_en;      // keeps cfg_ready low until the first clock after reset
    logic [1:0]         clr_cnt;
    logic [ROW_W-1:0]   num_rows;
    logic [ROW_W-1:0]   row_idx;
    logic [CHUNK_W-1:0] chunks_per_row;

    logic cfg_fire;
    logic cfg_ok;
    logic chunk_accept;
    logic count_window;
    logic issue_room;
    logic last_issue;
    logic last_done;
    logic spurious;
    logic last_row;

    assign cfg_ready    = out_en && (state == ST_IDLE);
    assign cfg_fire     = cfg_valid && cfg_ready;
    assign cfg_ok       = (cfg_num_rows != '0) && (cfg_chunks_per_row != '0);
    assign chunk_ready  = (state == ST_FEED) && issue_room;
    assign chunk_accept = chunk_valid && chunk_ready;
    assign count_window = (state == ST_FEED) || (state == ST_DRAIN);
    // The accumulator keeps its value through OUTPUT; only CLEAR (and IDLE) zero it
    assign org_start    = count_window || (state == ST_OUTPUT);
    assign res_valid    = (state == ST_OUTPUT);
    assign busy         = (state != ST_IDLE);
    assign last_row     = (row_idx == num_rows - 1'b1);

    chunk_completion_counter #(
        .CHUNK_W (CHUNK_W)
    ) u_counter (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (state == ST_CLEAR),
        .chunks_per_row (chunks_per_row),
        .count_window   (count_window),
        .chunk_accept   (chunk_accept),
        .final_finish   (org_final_finish),
        .issue_room     (issue_room),
        .last_issue     (last_issue),
        .last_done      (last_done),
        .spurious       (spurious)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            out_en           <= 1'b0;
            clr_cnt          <= '0;
            num_rows         <= '0;
            row_idx          <= '0;
            chunks_per_row   <= '0;
            org_chunk_strobe <= 1'b0;
            org_row_input    <= '0;
            res_data         <= '0;
            res_row_idx      <= '0;
            res_last         <= 1'b0;
            err_spurious     <= 1'b0;
            err_cfg          <= 1'b0;
        end else begin
            out_en           <= 1'b1;
            org_chunk_strobe <= chunk_accept;
            if (chunk_accept) begin
                org_row_input <= chunk_data;
            end
            if (spurious) begin
                err_spurious <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        if (cfg_ok) begin
                            num_rows       <= cfg_num_rows;
                            chunks_per_row <= cfg_chunks_per_row;
                            row_idx        <= '0;
                            clr_cnt        <= '0;
                            err_cfg        <= 1'b0;
                            // A stray completion in this same cycle still counts
                            err_spurious   <= spurious;
                            state          <= ST_CLEAR;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == CLEAR_LAST) begin
                        clr_cnt <= '0;
                        state   <= ST_FEED;
                    end else begin
                        clr_cnt <= clr_cnt + 2'd1;
                    end
                end
                ST_FEED, ST_DRAIN: begin
                    if (last_done) begin
                        // Running sum is valid alongside the completion pulse
                        res_data    <= org_adder_output;
                        res_row_idx <= row_idx;
                        res_last    <= last_row;
                        state       <= ST_OUTPUT;
                    end else if (last_issue) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        if (res_last) begin
                            state <= ST_IDLE;
                        end else begin
                            row_idx <= row_idx + 1'b1;
                            clr_cnt <= '0;
                            state   <= ST_CLEAR;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_reduction_sequencer.sv
// Bench for row_reduction_sequencer with a behavioural organizer model
// (5-cycle chunk-to-finish latency, float sums of small integer values).
module tb_row_reduction_sequencer;

  localparam int EW = 32;
  localparam int NU = 8;
  localparam int RW = 10;
  localparam int CW = 5;
  localparam int SBW = 1 + RW + EW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [RW-1:0]     cfg_num_rows = '0;
  logic [CW-1:0]     cfg_chunks_per_row = '0;
  logic              chunk_valid = 1'b0;
  logic              chunk_ready;
  logic [NU*EW-1:0]  chunk_data = '0;
  logic              org_start;
  logic              org_chunk_strobe;
  logic [NU*EW-1:0]  org_row_input;
  logic              org_final_finish;
  logic [EW-1:0]     org_adder_output;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [EW-1:0]     res_data;
  logic [RW-1:0]     res_row_idx;
  logic              res_last;
  logic              busy;
  logic              err_spurious;
  logic              err_cfg;

  logic              inj_finish = 1'b0;

  row_reduction_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .cfg_num_rows       (cfg_num_rows),
    .cfg_chunks_per_row (cfg_chunks_per_row),
    .chunk_valid        (chunk_valid),
    .chunk_ready        (chunk_ready),
    .chunk_data         (chunk_data),
    .org_start          (org_start),
    .org_chunk_strobe   (org_chunk_strobe),
    .org_row_input      (org_row_input),
    .org_final_finish   (org_final_finish),
    .org_adder_output   (org_adder_output),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .res_row_idx        (res_row_idx),
    .res_last           (res_last),
    .busy               (busy),
    .err_spurious       (err_spurious),
    .err_cfg            (err_cfg)
  );

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- float helpers (small non-negative integers only) ----------------
  function automatic logic [31:0] int2f(input int v);
    int msb;
    logic [31:0] m;
    if (v <= 0) return 32'h0;
    msb = 0;
    for (int i = 0; i < 24; i++) if (v[i]) msb = i;
    m = 32'(v) << (23 - msb);
    return {1'b0, 8'(127 + msb), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] b);
    logic [23:0] m;
    int sh;
    if (b[30:23] == 8'd0) return 0;
    m = {1'b1, b[22:0]};
    sh = 150 - int'(b[30:23]);
    return int'(m >> sh);
  endfunction

  // ---------------- organizer model ----------------
  logic [4:0]  pipe_v;
  logic [31:0] pipe_s [5];
  int          acc;
  int          nsum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      acc <= 0;
      for (int i = 0; i < 5; i++) pipe_s[i] <= '0;
    end else begin
      nsum = org_start ? acc : 0;
      if (org_chunk_strobe)
        for (int e = 0; e < NU; e++) nsum = nsum + f2i(org_row_input[e*EW +: EW]);
      acc <= nsum;
      pipe_v <= {pipe_v[3:0], org_chunk_strobe};
      pipe_s[0] <= int2f(nsum);
      for (int i = 1; i < 5; i++) pipe_s[i] <= pipe_s[i-1];
    end
  end

  assign org_final_finish = pipe_v[4] | inj_finish;
  assign org_adder_output = pipe_s[4];

  // ---------------- scoreboard ----------------
  logic [SBW-1:0] exp_q[$];
  logic [EW-1:0]  got_q[$];
  int strobe_cnt = 0;
  int low_run = 0;
  int low_runs[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (org_chunk_strobe) strobe_cnt++;
      if (busy && !org_start) low_run++;
      else if (low_run != 0) begin
        low_runs.push_back(low_run);
        low_run = 0;
      end
      if (res_valid && res_ready) begin
        logic [SBW-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL result_unexpected: got data=%h idx=%0d last=%0b, required none", res_data, res_row_idx, res_last);
        end else begin
          e = exp_q.pop_front();
          if ({res_last, res_row_idx, res_data} !== e) begin
            n_fail++;
            $display("FAIL result: got last=%0b idx=%0d data=%h, required last=%0b idx=%0d data=%h",
                     res_last, res_row_idx, res_data, e[SBW-1], e[EW +: RW], e[EW-1:0]);
          end
        end
        got_q.push_back(res_data);
      end
    end else begin
      low_run = 0;
    end
  end

  // ---------------- driver tasks (all start and end at posedge+#1) ----------------
  task automatic do_cfg(input int rows, input int cpr);
    int t;
    cfg_valid = 1'b1;
    cfg_num_rows = RW'(rows);
    cfg_chunks_per_row = CW'(cpr);
    t = 0;
    while (!cfg_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL cfg_timeout: cfg_ready=%0b, required 1", cfg_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drive_row(input int k, input int cpr, input bit stall, input bit rnd,
                           input bit last, input bit push);
    int t;
    int ev;
    int rowsum;
    logic [NU*EW-1:0] d;
    rowsum = 0;
    for (int j = 0; j < cpr; j++) begin
      if (stall) begin
        chunk_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
      for (int e = 0; e < NU; e++) begin
        ev = rnd ? int'($urandom_range(0, 7)) : k + 1;
        d[e*EW +: EW] = int2f(ev);
        rowsum += ev;
      end
      chunk_valid = 1'b1;
      chunk_data = d;
      t = 0;
      while (!chunk_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL chunk_timeout: row %0d chunk %0d chunk_ready=%0b, required 1", k, j, chunk_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (org_chunk_strobe !== 1'b1 || org_row_input !== d) begin
        n_fail++;
        $display("FAIL chunk_forward: strobe=%0b input=%h, required strobe=1 input=%h", org_chunk_strobe, org_row_input, d);
      end
    end
    chunk_valid = 1'b0;
    n_checks++;
    if (chunk_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL chunk_ready_after_last: got %0b, required 0", chunk_ready);
    end
    if (push) exp_q.push_back({last, RW'(k), int2f(rowsum)});
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 1000) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (t >= 1000) begin
      n_fail++;
      $display("FAIL done_timeout: busy=%0b pending=%0d, required busy=0 pending=0", busy, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({cfg_ready, chunk_ready, org_start, org_chunk_strobe, org_row_input, res_valid, res_data,
         res_row_idx, res_last, busy, err_spurious, err_cfg} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: cfg_ready=%0b busy=%0b res_valid=%0b org_start=%0b, required all 0",
               cfg_ready, busy, res_valid, org_start);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_ready_at_release: got %0b, required 0", cfg_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_ready_after_clock: cfg_ready=%0b busy=%0b, required 1 0", cfg_ready, busy);
    end
  endtask

  task automatic test_single_row();
    got_q.delete();
    do_cfg(1, 2);
    n_checks++;
    if (org_start !== 1'b0 || chunk_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_t1: org_start=%0b chunk_ready=%0b busy=%0b, required 0 0 1", org_start, chunk_ready, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (org_start !== 1'b0 || chunk_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_t2: org_start=%0b chunk_ready=%0b, required 0 0", org_start, chunk_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (org_start !== 1'b1 || chunk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL feed_t3: org_start=%0b chunk_ready=%0b, required 1 1", org_start, chunk_ready);
    end
    drive_row(0, 2, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h41800000) begin
      n_fail++;
      $display("FAIL single_row_sum: count=%0d first=%h, required 1 41800000", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 32'h0);
    end
  endtask

  task automatic test_multi_row();
    logic [31:0] want [3];
    want[0] = 32'h41000000; want[1] = 32'h41800000; want[2] = 32'h41C00000;
    got_q.delete();
    low_runs.delete();
    do_cfg(3, 1);
    for (int k = 0; k < 3; k++) drive_row(k, 1, 1'b0, 1'b0, k == 2, 1'b1);
    wait_done();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_q.size() <= k || got_q[k] !== want[k]) begin
        n_fail++;
        $display("FAIL multi_row_sum%0d: got %h, required %h", k, got_q.size() > k ? got_q[k] : 32'h0, want[k]);
      end
    end
    n_checks++;
    if (low_runs.size() != 3) begin
      n_fail++;
      $display("FAIL clear_windows: got %0d, required 3", low_runs.size());
    end
    foreach (low_runs[i]) begin
      n_checks++;
      if (low_runs[i] != 2) begin
        n_fail++;
        $display("FAIL clear_len%0d: got %0d cycles, required 2", i, low_runs[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int t;
    logic [EW-1:0] held;
    res_ready = 1'b0;
    do_cfg(2, 1);
    drive_row(0, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    t = 0;
    while (!res_valid && t < 100) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (t >= 100) begin
      n_fail++;
      $display("FAIL res_valid_timeout: got %0b, required 1", res_valid);
    end
    held = res_data;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== held || chunk_ready !== 1'b0 || org_start !== 1'b1) begin
        n_fail++;
        $display("FAIL output_hold%0d: valid=%0b data=%h chunk_ready=%0b org_start=%0b, required 1 %h 0 1",
                 c, res_valid, res_data, chunk_ready, org_start, held);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0 || org_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_clear: res_valid=%0b org_start=%0b busy=%0b, required 0 0 1", res_valid, org_start, busy);
    end
    drive_row(1, 1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done();
  endtask

  task automatic test_stall();
    int s0;
    s0 = strobe_cnt;
    do_cfg(1, 4);
    drive_row(0, 4, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done();
    n_checks++;
    if (strobe_cnt - s0 != 4) begin
      n_fail++;
      $display("FAIL stall_strobes: got %0d, required 4", strobe_cnt - s0);
    end
  endtask

  task automatic test_errors();
    do_cfg(5, 0);
    n_checks++;
    if (err_cfg !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cfg_chunks: err_cfg=%0b busy=%0b, required 1 0", err_cfg, busy);
    end
    do_cfg(0, 3);
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (err_cfg !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cfg_rows: err_cfg=%0b busy=%0b cfg_ready=%0b, required 1 0 1", err_cfg, busy, cfg_ready);
    end
    n_checks++;
    if (err_spurious !== 1'b0) begin
      n_fail++;
      $display("FAIL err_spurious_quiet: got %0b, required 0", err_spurious);
    end
    inj_finish = 1'b1;
    @(posedge clk); #1;
    inj_finish = 1'b0;
    n_checks++;
    if (err_spurious !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_spurious_idle: err_spurious=%0b busy=%0b, required 1 0", err_spurious, busy);
    end
    do_cfg(1, 1);
    n_checks++;
    if (err_spurious !== 1'b0 || err_cfg !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear: err_spurious=%0b err_cfg=%0b busy=%0b, required 0 0 1", err_spurious, err_cfg, busy);
    end
    drive_row(0, 1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done();
  endtask

  task automatic test_reset_abort();
    do_cfg(2, 2);
    drive_row(0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cfg_ready, chunk_ready, org_start, org_chunk_strobe, org_row_input, res_valid, res_data,
         res_row_idx, res_last, busy, err_spurious, err_cfg} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%0b org_start=%0b strobe=%0b res_valid=%0b, required all 0",
               busy, org_start, org_chunk_strobe, res_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cfg(2, 2);
    drive_row(0, 2, 1'b0, 1'b1, 1'b0, 1'b1);
    drive_row(1, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done();
    n_checks++;
    if (err_spurious !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_spurious: got %0b, required 0", err_spurious);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_multi_row();
    test_backpressure();
    test_stall();
    test_errors();
    test_reset_abort();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_results: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
